// File: rtl/bit_adder_pkg.sv
// Shared constants and helpers for the bit_adder ripple-carry adder.
package bit_adder_pkg;

  localparam int unsigned DefaultWidth = 64;

  // Signed overflow: the carry into the MSB disagrees with the carry out of it.
  function automatic logic signed_ovf(input logic carry_into_msb, input logic carry_out_msb);
    return carry_into_msb ^ carry_out_msb;
  endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell used to build the ripple-carry chain.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic p;

  assign p    = a ^ b;
  assign s    = p ^ cin;
  assign cout = (a & b) | (cin & p);

endmodule

// File: rtl/bit_adder.sv
// Registered WIDTH-bit two's-complement adder with signed-overflow flag.
module bit_adder
  import bit_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y,
  output logic             ovf
);

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum;
  logic             ovf_d;

  assign carry[0] = 1'b0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    full_adder u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (carry[i]),
      .s    (sum[i]),
      .cout (carry[i+1])
    );
  end

  assign ovf_d = signed_ovf(carry[WIDTH-1], carry[WIDTH]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y   <= '0;
      ovf <= 1'b0;
    end else begin
      y   <= sum;
      ovf <= ovf_d;
    end
  end

endmodule

// File: tb/tb_bit_adder.sv
// Self-checking bench for bit_adder: arithmetic reference model plus directed literal vectors.
module tb_bit_adder;

  localparam int unsigned W = 64;

  logic         clk;
  logic         rst;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] y;
  logic         ovf;

  int errors = 0;
  int checks = 0;
  bit cmp_en = 1'b0;

  logic [W-1:0] exp_y;
  logic         exp_ovf;

  bit_adder #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .a   (a),
    .b   (b),
    .y   (y),
    .ovf (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: sign-extend to W+1 bits and add; overflow when the extended sum
  // cannot be represented in W bits (its top two bits differ).
  function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] z);
    logic signed [W:0] full;
    full = $signed({x[W-1], x}) + $signed({z[W-1], z});
    return {full[W] != full[W-1], full[W-1:0]};
  endfunction

  always @(posedge clk or posedge rst) begin
    logic [W:0] r;
    if (rst) begin
      exp_y   = '0;
      exp_ovf = 1'b0;
    end else begin
      r       = ref_add(a, b);
      exp_y   = r[W-1:0];
      exp_ovf = r[W];
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      checks++;
      if (y !== exp_y || ovf !== exp_ovf) begin
        errors++;
        $display("FAIL model_cmp t=%0t: got y=%h ovf=%b, want y=%h ovf=%b",
                 $time, y, ovf, exp_y, exp_ovf);
      end
    end
  end

  task automatic check_lit(input string name, input logic [W-1:0] ey, input logic eo);
    checks++;
    if (y !== ey || ovf !== eo) begin
      errors++;
      $display("FAIL %s: got y=%h ovf=%b, want y=%h ovf=%b", name, y, ovf, ey, eo);
    end
  endtask

  // Drive operands between edges, then sample 3 time units after the capturing edge.
  task automatic step(input logic [W-1:0] va, input logic [W-1:0] vb);
    a = va;
    b = vb;
    @(posedge clk);
    #3;
  endtask

  initial begin
    rst = 1'b0;
    a   = 64'h1234_5678_9ABC_DEF0;
    b   = 64'h0FED_CBA9_8765_4321;
    #1 rst = 1'b1;
    #1;
    check_lit("reset_no_clock", 64'h0, 1'b0);
    cmp_en = 1'b1;
    @(posedge clk);
    #3 rst = 1'b0;

    step(64'h0, 64'h0);
    check_lit("zero_plus_zero", 64'h0, 1'b0);
    step(64'h405, 64'h403);
    check_lit("small_pos", 64'h808, 1'b0);
    step(64'h5D9F, 64'hF0CB2);
    check_lit("pos_pos", 64'hF6A51, 1'b0);
    step(64'h2435, 64'hFFFFF088_00000000);
    check_lit("pos_neg", 64'hFFFFF088_00002435, 1'b0);
    step(64'hFFF3E73F_00000000, 64'h00000AB7_00000000);
    check_lit("neg_pos", 64'hFFF3F1F6_00000000, 1'b0);
    step(64'hFFF3C038_00000000, 64'hFFFFF7ED_00000000);
    check_lit("neg_neg_carry", 64'hFFF3B825_00000000, 1'b0);
    step(64'h7FFFFFFF_FFFFFFFF, 64'h1);
    check_lit("max_pos_ovf", 64'h80000000_00000000, 1'b1);
    step(64'h80000000_00000000, 64'h80000000_00000000);
    check_lit("min_neg_ovf", 64'h0, 1'b1);
    step(64'hFFFFFFFF_FFFFFFFF, 64'h1);
    check_lit("minus1_plus1", 64'h0, 1'b0);

    // Asynchronous reset pulse while y holds a nonzero, overflowed sum.
    step(64'h7FFFFFFF_FFFFFFFF, 64'h7FFFFFFF_FFFFFFFF);
    check_lit("pre_reset", 64'hFFFFFFFF_FFFFFFFE, 1'b1);
    a = 64'h11;
    b = 64'h22;
    rst = 1'b1;
    #1;
    check_lit("async_reset", 64'h0, 1'b0);
    #1 rst = 1'b0;
    @(posedge clk);
    #3;
    check_lit("post_reset_load", 64'h33, 1'b0);

    // Operand changes between edges must not disturb the registered sum.
    step(64'h100, 64'h200);
    check_lit("hold_before", 64'h300, 1'b0);
    a = 64'h1;
    b = 64'h2;
    #1;
    check_lit("hold_between", 64'h300, 1'b0);
    @(posedge clk);
    #3;
    check_lit("hold_after", 64'h3, 1'b0);

    @(posedge clk);
    #3;
    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
